code_entry_tx: RTL and testbench



---
 rtl/code_entry_tx.sv | 183 ++++++++++++++++++
 tb/tb_code_entry_tx.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_entry_tx.sv
// Button-driven code entry front-end: debounce, assemble, hand off via valid/ready.
// Define CODE_ENTRY_PARITY_EN to drive code_parity; otherwise it is tied to 0.
module code_entry_tx #(
  parameter int CODE_W         = 7,
  parameter int DEB_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          btn_zero,
  input  logic                          btn_one,
  input  logic                          btn_enter,
  input  logic                          btn_clear,
  output logic [CODE_W-1:0]             code,
  output logic [$clog2(CODE_W+1)-1:0]   code_len,
  output logic                          code_parity,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic                          entry_active,
  output logic                          timeout_pulse
);

  localparam int LW = $clog2(CODE_W+1);
  localparam int DW = $clog2(DEB_CYCLES+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_SEND
  } state_t;

  // Button lanes: 3=clear 2=enter 1=one 0=zero
  logic [3:0]         raw;
  logic [3:0]         meta_q;
  logic [3:0]         sync_q;
  logic [3:0]         deb_q;
  logic [3:0]         deb_d;
  logic [3:0]         press_q;
  logic [3:0]         press_d;
  logic [3:0][DW-1:0] cnt_q;
  logic [3:0][DW-1:0] cnt_d;

  assign raw = {btn_clear, btn_enter, btn_one, btn_zero};

  always_comb begin
    deb_d   = deb_q;
    cnt_d   = '0;
    press_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DW'(DEB_CYCLES-1)) begin
          deb_d[i]   = sync_q[i];
          press_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= '0;
      sync_q  <= '0;
      deb_q   <= '0;
      press_q <= '0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= raw;
      sync_q  <= meta_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  logic ev_clr;
  logic ev_ent;
  logic ev_one;
  logic ev_zero;
  logic ev_bit;

  assign ev_clr  = press_q[3];
  assign ev_ent  = press_q[2] & ~press_q[3];
  assign ev_one  = press_q[1] & ~|press_q[3:2];
  assign ev_zero = press_q[0] & ~|press_q[3:1];
  assign ev_bit  = ev_one | ev_zero;

  state_t            state_q;
  state_t            state_d;
  logic [CODE_W-1:0] sr_q;
  logic [CODE_W-1:0] sr_d;
  logic [LW-1:0]     len_q;
  logic [LW-1:0]     len_d;
  logic [TW-1:0]     tmo_q;
  logic [TW-1:0]     tmo_d;
  logic              tpulse_q;
  logic              tpulse_d;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    len_d    = len_q;
    tmo_d    = tmo_q;
    tpulse_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (ev_bit) begin
          sr_d    = CODE_W'(ev_one);
          len_d   = LW'(1);
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        tmo_d = tmo_q + 1'b1;
        if (ev_clr) begin
          sr_d    = '0;
          len_d   = '0;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else if (ev_ent) begin
          tmo_d   = '0;
          state_d = S_SEND;
        end else if (ev_bit) begin
          sr_d  = (sr_q << 1) | CODE_W'(ev_one);
          len_d = len_q + 1'b1;
          tmo_d = '0;
          if (len_q == LW'(CODE_W-1)) begin
            state_d = S_SEND;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES-1)) begin
          sr_d     = '0;
          len_d    = '0;
          tmo_d    = '0;
          tpulse_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_SEND: begin
        tmo_d = '0;
        if (code_ready) begin
          sr_d    = '0;
          len_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      len_q    <= '0;
      tmo_q    <= '0;
      tpulse_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      len_q    <= len_d;
      tmo_q    <= tmo_d;
      tpulse_q <= tpulse_d;
    end
  end

  assign code          = sr_q;
  assign code_len      = len_q;
  assign code_valid    = (state_q == S_SEND);
  assign entry_active  = (state_q == S_ENTRY);
  assign timeout_pulse = tpulse_q;

`ifdef CODE_ENTRY_PARITY_EN
  assign code_parity = ^sr_q;
`else
  assign code_parity = 1'b0;
`endif

endmodule

// File: tb/tb_code_entry_tx.sv
// Bench for code_entry_tx: directed table, corner sequences, randomized entries.
// Expected parity follows CODE_ENTRY_PARITY_EN.
module tb_code_entry_tx;

  localparam int CW  = 7;
  localparam int DEB = 4;
  localparam int TMO = 50;
`ifdef CODE_ENTRY_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bz  = 1'b0;
  logic          bo  = 1'b0;
  logic          be  = 1'b0;
  logic          bc  = 1'b0;
  logic          rdy = 1'b0;
  logic [CW-1:0] code;
  logic [2:0]    code_len;
  logic          code_parity;
  logic          code_valid;
  logic          entry_active;
  logic          timeout_pulse;

  code_entry_tx #(
    .CODE_W(CW),
    .DEB_CYCLES(DEB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_zero(bz),
    .btn_one(bo),
    .btn_enter(be),
    .btn_clear(bc),
    .code(code),
    .code_len(code_len),
    .code_parity(code_parity),
    .code_valid(code_valid),
    .code_ready(rdy),
    .entry_active(entry_active),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] code;
    logic [2:0] len;
    logic       par;
  } xfer_t;

  xfer_t xq[$];
  int    errors = 0;
  int    checks = 0;
  int    vcyc = 0;
  int    tp_cnt = 0;
  int    hold_bad = 0;
  int    hold_seen = 0;
  logic  pv = 1'b0;
  logic  px = 1'b0;
  xfer_t prec;

  // Transfer log and hold-stability watcher, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      px = 1'b0;
    end else begin
      if (code_valid && pv && !px) begin
        hold_seen++;
        if (code !== prec.code || code_len !== prec.len ||
            code_parity !== prec.par) hold_bad++;
      end
      if (timeout_pulse) tp_cnt++;
      if (code_valid) vcyc++;
      if (code_valid && rdy) xq.push_back('{code, code_len, code_parity});
      pv = code_valid;
      px = code_valid && rdy;
      prec = '{code, code_len, code_parity};
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic press(input logic z, input logic o, input logic e,
                       input logic c, input int hold, input int gap);
    bz = z; bo = o; be = e; bc = c;
    repeat (hold) step();
    bz = 1'b0; bo = 1'b0; be = 1'b0; bc = 1'b0;
    repeat (gap) step();
  endtask

  task automatic expect_xfer(input string nm, input logic [6:0] c,
                             input logic [2:0] l, input logic p,
                             input int n0, input bit rnd);
    bit    ok;
    xfer_t x;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (xq.size() > n0) begin
        ok = 1'b1;
        break;
      end
      if (rnd) rdy = 1'($urandom_range(0, 1));
      step();
    end
    chk({nm, "_delivered"}, 32'(ok), 32'd1);
    if (ok) begin
      x = xq.pop_front();
      chk({nm, "_code"}, 32'(x.code), 32'(c));
      chk({nm, "_len"}, 32'(x.len), 32'(l));
      chk({nm, "_par"}, 32'(x.par), 32'(PAR_EN ? p : 1'b0));
    end
  endtask

  typedef struct {
    int         n;
    logic [6:0] seq;
    logic [6:0] code;
    logic [2:0] len;
    logic       par;
  } vec_t;

  vec_t tv[8];

  initial begin
    int    n0;
    int    v0;
    int    t0;
    int    act;
    int    pul;
    int    val;
    int    n;
    int    kab;
    bit    abort;
    logic  b;
    vec_t  r;

    // seq: bits in press order, left-aligned; code: expected right-aligned word
    tv[0] = '{7, 7'b1011001, 7'b1011001, 3'd7, 1'b0};
    tv[1] = '{2, 7'b1100000, 7'b0000011, 3'd2, 1'b0};
    tv[2] = '{1, 7'b0000000, 7'b0000000, 3'd1, 1'b0};
    tv[3] = '{3, 7'b1010000, 7'b0000101, 3'd3, 1'b0};
    tv[4] = '{7, 7'b1111111, 7'b1111111, 3'd7, 1'b1};
    tv[5] = '{4, 7'b1000000, 7'b0001000, 3'd4, 1'b1};
    tv[6] = '{5, 7'b0110100, 7'b0001101, 3'd5, 1'b1};
    tv[7] = '{6, 7'b0000010, 7'b0000001, 3'd6, 1'b1};

    repeat (3) step();
    chk("rst_valid", 32'(code_valid), 0);
    chk("rst_code", 32'(code), 0);
    chk("rst_len", 32'(code_len), 0);
    chk("rst_active", 32'(entry_active), 0);
    chk("rst_tpulse", 32'(timeout_pulse), 0);
    chk("rst_par", 32'(code_parity), 0);
    rst = 1'b0;
    step();

    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r  = tv[i];
      n0 = xq.size();
      v0 = vcyc;
      for (int k = 0; k < r.n; k++) begin
        b = r.seq[6-k];
        press(~b, b, 1'b0, 1'b0, 10, 10);
      end
      if (r.n < 7) press(1'b0, 1'b0, 1'b1, 1'b0, 10, 10);
      expect_xfer($sformatf("vec%0d", i), r.code, r.len, r.par, n0, 1'b0);
      repeat (5) step();
      chk($sformatf("vec%0d_valid_cycles", i), 32'(vcyc - v0), 1);
    end

    // Held valid with ready low, single-cycle handshake release
    rdy = 1'b0;
    n0  = xq.size();
    press(1'b0, 1'b1, 1'b0, 1'b0, 10, 10);
    press(1'b0, 1'b1, 1'b0, 1'b0, 10, 10);
    press(1'b0, 1'b0, 1'b1, 1'b0, 10, 10);
    v0 = vcyc;
    repeat (20) step();
    chk("s2_valid_held", 32'(code_valid), 1);
    chk("s2_code", 32'(code), 32'h03);
    chk("s2_len", 32'(code_len), 2);
    chk("s2_held_cycles", 32'(vcyc - v0 >= 20), 1);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    chk("s2_valid_drop", 32'(code_valid), 0);
    expect_xfer("s2", 7'b0000011, 3'd2, 1'b0, n0, 1'b0);

    // Short glitch then bounce then steady press: one event only
    rdy = 1'b1;
    bo  = 1'b1;
    repeat (3) step();
    for (int k = 0; k < 8; k++) begin
      bo = 1'(k % 2);
      step();
    end
    bo = 1'b1;
    repeat (20) step();
    chk("s3_active", 32'(entry_active), 1);
    chk("s3_len", 32'(code_len), 1);
    chk("s3_code", 32'(code), 1);
    bo = 1'b0;
    repeat (10) step();
    n0 = xq.size();
    press(1'b0, 1'b0, 1'b1, 1'b0, 10, 10);
    expect_xfer("s3", 7'b0000001, 3'd1, 1'b1, n0, 1'b0);

    // Abandoned entry times out
    n0  = xq.size();
    act = 0;
    pul = 0;
    bz  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) bz = 1'b0;
      step();
      act += int'(entry_active);
      pul += int'(timeout_pulse);
    end
    chk("s4_pulses", 32'(pul), 1);
    chk("s4_duration", 32'(act >= 49 && act <= 51), 1);
    chk("s4_idle", 32'(entry_active), 0);
    chk("s4_len", 32'(code_len), 0);
    chk("s4_no_xfer", 32'(xq.size()), 32'(n0));

    // Clear and enter together: clear wins
    press(1'b0, 1'b1, 1'b0, 1'b0, 10, 10);
    press(1'b1, 1'b0, 1'b0, 1'b0, 10, 10);
    press(1'b0, 1'b1, 1'b0, 1'b0, 10, 10);
    chk("s5_len3", 32'(code_len), 3);
    n0 = xq.size();
    press(1'b0, 1'b0, 1'b1, 1'b1, 10, 10);
    chk("s5_idle", 32'(entry_active), 0);
    chk("s5_len", 32'(code_len), 0);
    chk("s5_code", 32'(code), 0);
    chk("s5_valid", 32'(code_valid), 0);
    chk("s5_no_xfer", 32'(xq.size()), 32'(n0));

    // Randomized entries against an arithmetic model
    t0 = tp_cnt;
    for (int e = 0; e < 40; e++) begin
      rdy   = 1'b0;
      n0    = xq.size();
      n     = int'($urandom_range(1, 7));
      abort = (n >= 2) && ($urandom_range(0, 4) == 0);
      kab   = int'($urandom_range(1, 6)) % n;
      if (kab == 0) kab = 1;
      val   = 0;
      if ($urandom_range(0, 5) == 0)
        press(1'b0, 1'b0, 1'b1, 1'b0, 10, 10);
      for (int k = 0; k < n; k++) begin
        if (abort && k == kab) break;
        b = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 5) == 0) begin
          b = 1'b1;
          press(1'b1, 1'b1, 1'b0, 1'b0,
                int'($urandom_range(8, 14)), int'($urandom_range(8, 14)));
        end else begin
          press(~b, b, 1'b0, 1'b0,
                int'($urandom_range(8, 14)), int'($urandom_range(8, 14)));
        end
        val = val * 2 + int'(b);
      end
      if (abort) begin
        press(1'b0, 1'b0, 1'b0, 1'b1, 10, 10);
        chk("rnd_abort_len", 32'(code_len), 0);
        chk("rnd_abort_idle", 32'(entry_active), 0);
        chk("rnd_abort_no_xfer", 32'(xq.size()), 32'(n0));
      end else begin
        if (n < 7) press(1'b0, 1'b0, 1'b1, 1'b0,
                         int'($urandom_range(8, 14)), 10);
        expect_xfer($sformatf("rnd%0d", e), 7'(val), 3'(n),
                    1'($countones(val) % 2), n0, 1'b1);
        rdy = 1'b0;
        repeat (3) step();
      end
    end
    chk("rnd_no_timeouts", 32'(tp_cnt - t0), 0);

    // Reset while presenting a code
    rdy = 1'b0;
    press(1'b0, 1'b1, 1'b0, 1'b0, 10, 10);
    press(1'b0, 1'b0, 1'b1, 1'b0, 10, 10);
    chk("s6_valid_before", 32'(code_valid), 1);
    n0 = xq.size();
    #1;
    rst = 1'b1;
    #1;
    chk("s6_async_valid", 32'(code_valid), 0);
    chk("s6_async_code", 32'(code), 0);
    chk("s6_async_len", 32'(code_len), 0);
    chk("s6_async_active", 32'(entry_active), 0);
    chk("s6_async_par", 32'(code_parity), 0);
    repeat (2) step();
    rst = 1'b0;
    rdy = 1'b1;
    repeat (30) step();
    chk("s6_no_stale_valid", 32'(code_valid), 0);
    chk("s6_no_stale_xfer", 32'(xq.size()), 32'(n0));

    chk("hold_stable", 32'(hold_bad), 0);
    chk("hold_observed", 32'(hold_seen > 0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
